// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Byte-stream program loader; writes framed 16-bit words into
//            program memory and holds the core in reset until a good frame.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter logic [7:0] START_BYTE = 8'hA5,
  parameter int         TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LEN  = 3'd1;
  localparam logic [2:0] c_HI   = 3'd2;
  localparam logic [2:0] c_LO   = 3'd3;
  localparam logic [2:0] c_CSUM = 3'd4;
  localparam logic [2:0] c_DONE = 3'd5;
  localparam logic [2:0] c_ERR  = 3'd6;

  localparam int              c_IW    = $clog2(TIMEOUT + 1);
  localparam logic [c_IW-1:0] c_TLAST = c_IW'(TIMEOUT - 1);

  logic [2:0]      r_state;
  logic [7:0]      r_n;
  logic [7:0]      r_hi;
  logic [7:0]      r_waddr;
  logic [7:0]      r_csum;
  logic [c_IW-1:0] r_idle;

  logic       w_xfer;
  logic [7:0] w_nlast;
  logic       w_last;
  logic       w_in_frame;

  assign w_xfer     = rx_valid & rx_ready;
  // N = 0 gives 255 here, so a 256-word frame ends at word address 255
  assign w_nlast    = r_n - 8'd1;
  assign w_last     = (r_waddr == w_nlast);
  assign w_in_frame = (r_state == c_LEN) || (r_state == c_HI) ||
                      (r_state == c_LO)  || (r_state == c_CSUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_n       <= 8'd0;
      r_hi      <= 8'd0;
      r_waddr   <= 8'd0;
      r_csum    <= 8'd0;
      r_idle    <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'd0;
      mem_wdata <= 16'd0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      mem_we   <= 1'b0;

      if (!w_in_frame || w_xfer) begin
        r_idle <= '0;
      end else if (r_idle == c_TLAST) begin
        r_idle  <= '0;
        r_state <= c_ERR;
        err     <= 1'b1;
        done    <= 1'b0;
      end else begin
        r_idle <= r_idle + 1'b1;
      end

      if (w_xfer) begin
        case (r_state)
          c_IDLE, c_DONE, c_ERR: begin
            if (rx_data == START_BYTE) begin
              r_state   <= c_LEN;
              done      <= 1'b0;
              err       <= 1'b0;
              core_hold <= 1'b1;
              r_waddr   <= 8'd0;
              r_csum    <= 8'd0;
            end
          end
          c_LEN: begin
            r_n     <= rx_data;
            r_state <= c_HI;
          end
          c_HI: begin
            r_hi    <= rx_data;
            r_csum  <= r_csum ^ rx_data;
            r_state <= c_LO;
          end
          c_LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= r_waddr;
            mem_wdata <= {r_hi, rx_data};
            r_csum    <= r_csum ^ rx_data;
            r_waddr   <= r_waddr + 8'd1;
            r_state   <= w_last ? c_CSUM : c_HI;
          end
          c_CSUM: begin
            if (rx_data == r_csum) begin
              r_state   <= c_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              r_state <= c_ERR;
              err     <= 1'b1;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Directed scoreboard bench for prog_loader (TIMEOUT = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_q[$];
  logic [15:0] wbuf[256];

  prog_loader #(
    .START_BYTE(8'hA5),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_hold(core_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every write strobe is matched against the oldest expected write
  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    #1;
    if (mem_we !== 1'b0) begin
      check("write_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int nw, input logic bad);
    logic [7:0] cs;
    logic [7:0] a;
    cs = 8'h00;
    a  = 8'h00;
    send(8'hA5);
    send((nw == 256) ? 8'h00 : 8'(nw));
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({a, wbuf[i]});
      send(wbuf[i][15:8]);
      send(wbuf[i][7:0]);
      cs = cs ^ wbuf[i][15:8] ^ wbuf[i][7:0];
      a  = a + 8'd1;
    end
    send(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_hold"}, 32'(core_hold), 32'(h));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    reset_values("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Good two-word frame, checksum 0x40
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'hABCD;
    send_frame(2, 1'b0);
    status("good", 1'b1, 1'b0, 1'b0);

    // Same frame with checksum 0x41: words stay written, error flagged
    send_frame(2, 1'b1);
    status("badcs", 1'b0, 1'b1, 1'b1);

    // Garbage outside a frame is ignored
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    check("garbage_err_kept", 32'(err), 32'd1);
    check("garbage_done", 32'(done), 32'd0);
    send_frame(2, 1'b0);
    status("after_garbage", 1'b1, 1'b0, 1'b0);

    // Timeout inside a frame
    send(8'hA5);
    send(8'h01);
    send(8'h12);
    repeat (16) tick();
    status("timeout", 1'b0, 1'b1, 1'b1);
    send(8'hA5);
    check("restart_err_clear", 32'(err), 32'd0);
    check("restart_hold", 32'(core_hold), 32'd1);

    // Reset pulse mid-frame (frame A5,02,12,34,AB)
    exp_q.push_back({8'h00, 16'h1234});
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    check("pre_reset_writes_left", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    #2;
    reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_frame(2, 1'b0);
    status("post_reset", 1'b1, 1'b0, 1'b0);

    // N = 0: 256 words, addresses 0..255 in order
    for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
    send_frame(256, 1'b0);
    status("full256", 1'b1, 1'b0, 1'b0);
    check("full256_last_addr", 32'(mem_addr), 32'd255);
    check("full256_last_data", 32'(mem_wdata), 32'(wbuf[255]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
